// File: rtl/sram_ctrl.sv
// Host-side initiator for an asynchronous SRAM: one word per request, sequenced
// through SETUP, STROBE (WaitStates+1 clocks) and HOLD with registered strobes.
module sram_ctrl #(
  parameter int AddressSize = 8,
  parameter int WordSize    = 8,
  parameter int WaitStates  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   wr,
  input  logic [AddressSize-1:0] addr,
  input  logic [WordSize-1:0]    wdata,
  output logic                   ready,
  output logic [WordSize-1:0]    rdata,
  output logic                   rvalid,
  output logic [AddressSize-1:0] mem_addr,
  inout  wire  [WordSize-1:0]    mem_data,
  output logic                   mem_cs_n,
  output logic                   mem_we_n,
  output logic                   mem_oe_n
);

  localparam logic [3:0] WAIT_LOAD = 4'(WaitStates);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // state is the observable FSM state for checkers bound to this module.
  state_t                 state;
  state_t                 state_nx;
  logic [3:0]             wait_cnt;
  logic [3:0]             wait_cnt_nx;
  logic                   wr_q;
  logic                   wr_nx;
  logic [WordSize-1:0]    wdata_q;
  logic [WordSize-1:0]    wdata_nx;
  logic [AddressSize-1:0] addr_nx;
  logic                   capture;
  logic                   drive_en;

  logic ready_nx;
  logic rvalid_nx;
  logic cs_n_nx;
  logic we_n_nx;
  logic oe_n_nx;
  logic drive_nx;

  // Handshake: a request is taken on a rising edge where req && ready; ready is
  // high only in IDLE, and req seen while ready is low is dropped, not queued.
  assign mem_data = drive_en ? wdata_q : {WordSize{1'bz}};

  // State register plus the registered copies of every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      mem_addr <= '0;
      ready    <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= '0;
      mem_cs_n <= 1'b1;
      mem_we_n <= 1'b1;
      mem_oe_n <= 1'b1;
      drive_en <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      wr_q     <= wr_nx;
      wdata_q  <= wdata_nx;
      mem_addr <= addr_nx;
      ready    <= ready_nx;
      rvalid   <= rvalid_nx;
      mem_cs_n <= cs_n_nx;
      mem_we_n <= we_n_nx;
      mem_oe_n <= oe_n_nx;
      drive_en <= drive_nx;
      if (capture) begin
        rdata <= mem_data;
      end
    end
  end

  // Next-state logic, including the transaction latch and the strobe counter.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    wr_nx       = wr_q;
    wdata_nx    = wdata_q;
    addr_nx     = mem_addr;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (req && ready) begin
          state_nx = SETUP;
          wr_nx    = wr;
          wdata_nx = wdata;
          addr_nx  = addr;
        end
      end
      SETUP: begin
        state_nx    = STROBE;
        wait_cnt_nx = WAIT_LOAD;
      end
      STROBE: begin
        if (wait_cnt == 4'd0) begin
          state_nx = HOLD;
          capture  = !wr_q;
        end else begin
          wait_cnt_nx = wait_cnt - 4'd1;
        end
      end
      HOLD: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the flops show the phase
  // in the same cycle the FSM enters it.
  always_comb begin
    ready_nx  = (state_nx == IDLE);
    cs_n_nx   = (state_nx == IDLE);
    we_n_nx   = !((state_nx == STROBE) && wr_nx);
    oe_n_nx   = !((state_nx == STROBE) && !wr_nx);
    drive_nx  = (state_nx != IDLE) && wr_nx;
    rvalid_nx = (state_nx == HOLD) && !wr_nx;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Synchronous host-side controller that acts as the initiator for the team's asynchronous SRAM chip interface: active-low chip select, write enable and output enable, plus a shared tri-state data bus.
- Accepts single-word read/write requests over a req/ready handshake.
- Sequences CS_n/WE_n/OE_n through setup, strobe and hold phases with a programmable strobe width.
- Returns read data with a one-cycle valid pulse.
- Sits between on-chip logic and an external or behavioural SRAM.

Parameters:
- AddressSize, 8, width of the SRAM address bus.
- WordSize, 8, width of the SRAM data bus and host data.
- WaitStates, 1, extra strobe cycles; strobe phase lasts WaitStates+1 clocks (range 0..15).

Ports:
- clk  input  1  single system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  host request; accepted on a rising edge where req && ready.
- wr  input  1  1 = write, 0 = read; sampled with req.
- addr  input  AddressSize  host address; sampled with req.
- wdata  input  WordSize  host write data; sampled with req.
- ready  output  1  high only in IDLE; controller can accept a request.
- rdata  output  WordSize  read data; holds last read value.
- rvalid  output  1  one-cycle pulse when rdata is updated.
- mem_addr  output  AddressSize  SRAM address.
- mem_data  inout  WordSize  SRAM data bus; driven only during writes, else all-Z.
- mem_cs_n  output  1  SRAM chip select, active low.
- mem_we_n  output  1  SRAM write enable, active low.
- mem_oe_n  output  1  SRAM output enable, active low.

Behaviour:
- Reset: asynchronous, active-high. While rst is high:
  - state = IDLE; ready = 1; rvalid = 0; rdata = 0; mem_addr = 0.
  - mem_cs_n = mem_we_n = mem_oe_n = 1.
  - Data-bus drive enable = 0, so mem_data is Z.
  - Reset mid-transaction aborts the transaction immediately, with no completion and no rvalid pulse.
- Registers: all outputs are registered. mem_data is driven from the registered write-data and drive-enable flops.
- FSM states: IDLE, SETUP, STROBE, HOLD. A wait counter (4 bits) runs only in STROBE.
- Handshake: acceptance edge T = rising edge with req && ready. At T, latch addr/wdata/wr and go to SETUP. req while not ready is ignored (not queued).
- SETUP (1 cycle):
  - mem_cs_n = 0; mem_addr = latched address; WE_n = OE_n = 1.
  - Write: data bus is driven with latched data.
  - Next state: STROBE, counter loaded with WaitStates.
- STROBE (WaitStates+1 cycles):
  - Write: mem_we_n = 0, data still driven, OE_n = 1.
  - Read: mem_oe_n = 0, bus not driven, WE_n = 1.
  - Counter decrements each cycle; at 0, next state is HOLD.
  - Read capture: on the edge that leaves STROBE, capture mem_data into rdata.
- HOLD (1 cycle):
  - WE_n = OE_n = 1; CS_n = 0; address held.
  - Write: data still driven, which guarantees data hold after WE_n rises.
  - Read: rvalid = 1 for exactly this cycle.
  - Next state: IDLE.
- IDLE:
  - CS_n = WE_n = OE_n = 1; bus Z; ready = 1; mem_addr holds its last value.
- Back-to-back: a req present in IDLE is accepted on the next edge, so CS_n is high for at least 1 cycle between transactions.
- Transaction timing: from the cycle after T, ready is low for WaitStates+3 cycles.
- Invariants, which must never be violated:
  - mem_we_n and mem_oe_n never both 0.
  - The controller never drives mem_data while mem_oe_n = 0.
  - mem_addr and write data are stable whenever WE_n = 0.
  - WE_n/OE_n are only 0 when CS_n = 0.
- Boundaries:
  - addr = all-ones is a valid access with no wrap or special case.
  - WaitStates = 0 gives a 1-cycle strobe.
  - If the SRAM returns X/Z on a read, it is captured as-is; no checking.

Test Plan:
- Reset mid-write: assert rst while STROBE has mem_we_n = 0 → same-cycle mem_cs_n/we_n/oe_n = 1, mem_data = Z, ready = 1, no rvalid afterwards.
- Write then read, WaitStates = 1: write addr 0x3C data 0xA5 → SETUP 1 cycle, WE_n low 2 cycles, HOLD 1 cycle, ready low 4 cycles. Then read 0x3C → OE_n low 2 cycles, rvalid pulses once with rdata = 0xA5.
- Back-to-back with req held high: writes to 0x00 = 0x11 and 0xFF = 0x22 (address boundary), then reads of both → rdata 0x11 then 0x22. CS_n high ≥ 1 cycle between each transaction.
- Ignored request: toggle req with addr 0x55 during a busy read → exactly one transaction is executed, and rdata comes from the original address.
- WaitStates = 0 and WaitStates = 5: strobe widths of 1 and 6 cycles respectively; data integrity holds for pattern 0x5A/0xC3.
- Invariant checker running throughout all tests:
  - fail if mem_we_n = 0 && mem_oe_n = 0;
  - fail if the bus is driven while mem_oe_n = 0;
  - fail if mem_addr changes while CS_n = 0.
